// File: rtl/riscv_memmisaligned_split.sv
// Memory-side misalignment handler: single-beat word-contained accesses, two-beat
// split for word-crossing data accesses, and an error response for illegal ones.
package riscv_memmisaligned_split_pkg;
    typedef enum logic [2:0] {
        BYTE  = 3'b000,
        HWORD = 3'b001,
        WORD  = 3'b010,
        DWORD = 3'b011
    } biu_size_t;
endpackage

module riscv_memmisaligned_split
    import riscv_memmisaligned_split_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int HAS_RVC  = 0,
    parameter int SPLIT_EN = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic              instruction_i,
    input  logic              we_i,
    input  logic [XLEN-1:0]   adr_i,
    input  biu_size_t         size_i,
    input  logic [XLEN-1:0]   d_i,
    output logic              ready_o,
    output logic              ack_o,
    output logic [XLEN-1:0]   q_o,
    output logic              misaligned_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [XLEN-1:0]   mem_adr_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [XLEN-1:0]   mem_d_o,
    input  logic              mem_ack_i,
    input  logic [XLEN-1:0]   mem_q_i
);
    localparam int N    = XLEN / 8;
    localparam int OFFW = $clog2(N);

    typedef enum logic [2:0] {
        IDLE,
        BEAT0,
        BEAT1,
        RESP,
        ERR
    } state_t;

    state_t state_q, state_d;

    logic              fetch_q;
    logic              split_q;
    logic [OFFW-1:0]   off_q;
    logic [3:0]        bytes_q;
    logic [N-1:0]      be1_q;
    logic [XLEN-1:0]   d1_q;
    logic [XLEN-1:0]   q0_q;
    logic [XLEN-1:0]   q1_q;
    logic              memReq_q;
    logic              memWe_q;
    logic [XLEN-1:0]   memAdr_q;
    logic [N-1:0]      memBe_q;
    logic [XLEN-1:0]   memD_q;

    logic              sizeKnown;
    logic [3:0]        reqBytes;
    logic [OFFW-1:0]   reqOff;
    logic [4:0]        endByte;
    logic              crosses;
    logic              fetchMis;
    logic              reqErr;
    logic              reqSplit;
    logic [2*N-1:0]    baseMask;
    logic [2*N-1:0]    shiftedMask;
    logic [2*XLEN-1:0] wideData;

    always_comb begin
        sizeKnown = 1'b1;
        reqBytes  = 4'd1;
        case (size_i)
            BYTE:    reqBytes = 4'd1;
            HWORD:   reqBytes = 4'd2;
            WORD:    reqBytes = 4'd4;
            DWORD:   reqBytes = 4'd8;
            default: sizeKnown = 1'b0;
        endcase
    end

    // Request classification; error wins over everything, fetches are never split.
    always_comb begin
        reqOff   = adr_i[OFFW-1:0];
        endByte  = {1'b0, reqBytes} + 5'(reqOff);
        crosses  = endByte > 5'(N);
        fetchMis = (HAS_RVC != 0) ? adr_i[0] : |adr_i[1:0];
        reqErr   = !sizeKnown || (reqBytes > 4'(N))
                   || (instruction_i && fetchMis)
                   || (!instruction_i && crosses && (SPLIT_EN == 0));
        reqSplit = !instruction_i && crosses;
    end

    always_comb begin
        baseMask = '0;
        for (int i = 0; i < 2 * N; i++) begin
            baseMask[i] = (i < int'(reqBytes));
        end
        shiftedMask = baseMask << reqOff;
        wideData    = {{XLEN{1'b0}}, d_i} << {reqOff, 3'b000};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    state_d = reqErr ? ERR : BEAT0;
                end
            end
            BEAT0: begin
                if (mem_ack_i) begin
                    state_d = split_q ? BEAT1 : RESP;
                end
            end
            BEAT1: begin
                if (mem_ack_i) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory-side outputs are registered so they stay put while a beat is stalled.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            fetch_q  <= 1'b0;
            split_q  <= 1'b0;
            off_q    <= '0;
            bytes_q  <= '0;
            be1_q    <= '0;
            d1_q     <= '0;
            q0_q     <= '0;
            q1_q     <= '0;
            memReq_q <= 1'b0;
            memWe_q  <= 1'b0;
            memAdr_q <= '0;
            memBe_q  <= '0;
            memD_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        fetch_q <= instruction_i;
                        split_q <= reqSplit;
                        off_q   <= reqOff;
                        bytes_q <= reqBytes;
                        be1_q   <= shiftedMask[2*N-1:N];
                        d1_q    <= wideData[2*XLEN-1:XLEN];
                        q1_q    <= '0;
                        if (!reqErr) begin
                            memReq_q <= 1'b1;
                            memWe_q  <= we_i && !instruction_i;
                            memAdr_q <= adr_i & ~XLEN'(N - 1);
                            memBe_q  <= instruction_i ? {N{1'b1}} : shiftedMask[N-1:0];
                            memD_q   <= wideData[XLEN-1:0];
                        end
                    end
                end
                BEAT0: begin
                    if (mem_ack_i) begin
                        q0_q <= mem_q_i;
                        if (split_q) begin
                            memAdr_q <= memAdr_q + XLEN'(N);
                            memBe_q  <= be1_q;
                            memD_q   <= d1_q;
                        end else begin
                            memReq_q <= 1'b0;
                        end
                    end
                end
                BEAT1: begin
                    if (mem_ack_i) begin
                        q1_q     <= mem_q_i;
                        memReq_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    logic [2*XLEN-1:0] rdWide;
    logic [XLEN-1:0]   dataMask;
    logic [XLEN-1:0]   rdMerged;

    always_comb begin
        rdWide   = {q1_q, q0_q} >> {off_q, 3'b000};
        dataMask = '0;
        for (int i = 0; i < N; i++) begin
            dataMask[8*i +: 8] = {8{i < int'(bytes_q)}};
        end
        rdMerged = rdWide[XLEN-1:0] & dataMask;
    end

    assign ready_o      = (state_q == IDLE);
    assign ack_o        = (state_q == RESP) || (state_q == ERR);
    assign misaligned_o = (state_q == ERR);
    assign q_o          = (state_q == RESP) ? (fetch_q ? q0_q : rdMerged) : '0;
    assign mem_req_o    = memReq_q;
    assign mem_we_o     = memWe_q;
    assign mem_adr_o    = memAdr_q;
    assign mem_be_o     = memBe_q;
    assign mem_d_o      = memD_q;

endmodule

// File: tb/tb_riscv_memmisaligned_split.sv
// Directed bench: DUT A (RVC off, split on) and DUT B (RVC on, split off) share
// request fields and a tiny two-word memory model.
module tb_riscv_memmisaligned_split;
    import riscv_memmisaligned_split_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstN, reqA, reqB, instr, we, holdAck;
    logic [31:0] adr, d, loData, hiAdr, hiData;
    biu_size_t   size;

    logic        readyA, ackA, misA, memReqA, memWeA, memAckA;
    logic [31:0] qA, memAdrA, memDA, memQA;
    logic [3:0]  memBeA;
    logic        readyB, ackB, misB, memReqB, memWeB, memAckB;
    logic [31:0] qB, memAdrB, memDB, memQB;
    logic [3:0]  memBeB;

    assign memAckA = memReqA && !holdAck;
    assign memAckB = memReqB;
    assign memQA   = (memAdrA == hiAdr) ? hiData : loData;
    assign memQB   = (memAdrB == hiAdr) ? hiData : loData;

    riscv_memmisaligned_split #(.XLEN(32), .HAS_RVC(0), .SPLIT_EN(1)) dutA (
        .clk_i(clk), .rst_ni(rstN), .req_i(reqA), .instruction_i(instr), .we_i(we),
        .adr_i(adr), .size_i(size), .d_i(d), .ready_o(readyA), .ack_o(ackA), .q_o(qA),
        .misaligned_o(misA), .mem_req_o(memReqA), .mem_we_o(memWeA), .mem_adr_o(memAdrA),
        .mem_be_o(memBeA), .mem_d_o(memDA), .mem_ack_i(memAckA), .mem_q_i(memQA)
    );

    riscv_memmisaligned_split #(.XLEN(32), .HAS_RVC(1), .SPLIT_EN(0)) dutB (
        .clk_i(clk), .rst_ni(rstN), .req_i(reqB), .instruction_i(instr), .we_i(we),
        .adr_i(adr), .size_i(size), .d_i(d), .ready_o(readyB), .ack_o(ackB), .q_o(qB),
        .misaligned_o(misB), .mem_req_o(memReqB), .mem_we_o(memWeB), .mem_adr_o(memAdrB),
        .mem_be_o(memBeB), .mem_d_o(memDB), .mem_ack_i(memAckB), .mem_q_i(memQB)
    );

    int checkCount = 0;
    int errorCount = 0;

    bit          selB = 1'b0;
    bit          sawReq;
    int          ackSeen;
    logic [31:0] beatAdr[$];
    logic [3:0]  beatBe[$];
    logic [31:0] beatD[$];
    logic        beatWe[$];

    always @(negedge clk) begin
        if (selB ? (memReqB && memAckB) : (memReqA && memAckA)) begin
            beatAdr.push_back(selB ? memAdrB : memAdrA);
            beatBe.push_back(selB ? memBeB : memBeA);
            beatD.push_back(selB ? memDB : memDA);
            beatWe.push_back(selB ? memWeB : memWeA);
        end
        if (selB ? memReqB : memReqA) sawReq = 1'b1;
        if (selB ? ackB : ackA) ackSeen++;
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic clearLog();
        beatAdr.delete();
        beatBe.delete();
        beatD.delete();
        beatWe.delete();
        sawReq  = 1'b0;
        ackSeen = 0;
    endtask

    task automatic applyStimulus(input bit useB, input logic isInstr, input logic isWe,
                                 input logic [31:0] a, input biu_size_t s, input logic [31:0] data,
                                 output int ackCycle, output logic [31:0] qOut, output logic misOut);
        @(negedge clk);
        selB = useB;
        clearLog();
        instr = isInstr;
        we    = isWe;
        adr   = a;
        size  = s;
        d     = data;
        if (useB) reqB = 1'b1; else reqA = 1'b1;
        @(posedge clk);
        ackCycle = 0;
        qOut     = '0;
        misOut   = 1'b0;
        for (int n = 1; n <= 20 && ackCycle == 0; n++) begin
            @(negedge clk);
            reqA = 1'b0;
            reqB = 1'b0;
            if (useB ? ackB : ackA) begin
                ackCycle = n;
                qOut     = useB ? qB : qA;
                misOut   = useB ? misB : misA;
            end
        end
        if (ackCycle == 0) checkOutput("ackTimeout", 64'd0, 64'd1);
        @(negedge clk);
        checkOutput("readyAfterAck", useB ? readyB : readyA, 1);
    endtask

    int          lat;
    logic [31:0] q;
    logic        mis;

    initial begin
        rstN = 1'b0; reqA = 1'b0; reqB = 1'b0; instr = 1'b0; we = 1'b0; holdAck = 1'b0;
        adr = '0; d = '0; size = WORD; loData = '0; hiAdr = 32'hDEAD_0000; hiData = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        checkOutput("rstReady", readyA, 1);
        checkOutput("rstAck", ackA, 0);
        checkOutput("rstMis", misA, 0);
        checkOutput("rstMemReq", memReqA, 0);
        checkOutput("rstMemWe", memWeA, 0);
        checkOutput("rstQ", qA, 0);
        checkOutput("rstMemAdr", memAdrA, 0);
        checkOutput("rstMemBe", memBeA, 0);
        checkOutput("rstMemD", memDA, 0);

        // aligned word read
        loData = 32'hDDCC_BBAA;
        applyStimulus(0, 0, 0, 32'h1000, WORD, 0, lat, q, mis);
        checkOutput("alnLat", lat, 2);
        checkOutput("alnQ", q, 32'hDDCC_BBAA);
        checkOutput("alnMis", mis, 0);
        checkOutput("alnBeats", beatAdr.size(), 1);
        if (beatAdr.size() == 1) begin
            checkOutput("alnAdr", beatAdr[0], 32'h1000);
            checkOutput("alnBe", beatBe[0], 4'b1111);
        end

        // split word read
        loData = 32'h4433_2211; hiAdr = 32'h1004; hiData = 32'h8877_6655;
        applyStimulus(0, 0, 0, 32'h1003, WORD, 0, lat, q, mis);
        checkOutput("splitLat", lat, 3);
        checkOutput("splitQ", q, 32'h7766_5544);
        checkOutput("splitMis", mis, 0);
        checkOutput("splitBeats", beatAdr.size(), 2);
        if (beatAdr.size() == 2) begin
            checkOutput("splitAdr0", beatAdr[0], 32'h1000);
            checkOutput("splitBe0", beatBe[0], 4'b1000);
            checkOutput("splitAdr1", beatAdr[1], 32'h1004);
            checkOutput("splitBe1", beatBe[1], 4'b0111);
        end

        // split halfword write
        applyStimulus(0, 0, 1, 32'h1003, HWORD, 32'h0000_BEEF, lat, q, mis);
        checkOutput("wrLat", lat, 3);
        checkOutput("wrMis", mis, 0);
        checkOutput("wrBeats", beatAdr.size(), 2);
        if (beatAdr.size() == 2) begin
            checkOutput("wrAdr0", beatAdr[0], 32'h1000);
            checkOutput("wrBe0", beatBe[0], 4'b1000);
            checkOutput("wrD0", beatD[0], 32'hEF00_0000);
            checkOutput("wrWe0", beatWe[0], 1);
            checkOutput("wrAdr1", beatAdr[1], 32'h1004);
            checkOutput("wrBe1", beatBe[1], 4'b0001);
            checkOutput("wrD1", beatD[1], 32'h0000_00BE);
            checkOutput("wrWe1", beatWe[1], 1);
        end

        // byte read inside a word
        loData = 32'hDDCC_BBAA; hiAdr = 32'hDEAD_0000;
        applyStimulus(0, 0, 0, 32'h1001, BYTE, 0, lat, q, mis);
        checkOutput("byteLat", lat, 2);
        checkOutput("byteQ", q, 32'h0000_00BB);
        if (beatBe.size() == 1) checkOutput("byteBe", beatBe[0], 4'b0010);
        else checkOutput("byteBeats", beatBe.size(), 1);

        // fetch at 0x1002 without RVC is illegal
        applyStimulus(0, 1, 0, 32'h1002, WORD, 0, lat, q, mis);
        checkOutput("fetchErrLat", lat, 1);
        checkOutput("fetchErrMis", mis, 1);
        checkOutput("fetchErrQ", q, 0);
        checkOutput("fetchErrNoReq", sawReq, 0);

        // DWORD on a 32-bit port is illegal
        applyStimulus(0, 0, 0, 32'h1000, DWORD, 0, lat, q, mis);
        checkOutput("dwordLat", lat, 1);
        checkOutput("dwordMis", mis, 1);
        checkOutput("dwordNoReq", sawReq, 0);

        // fetch at 0x1002 with RVC is one full-word beat
        loData = 32'h1234_5678;
        applyStimulus(1, 1, 0, 32'h1002, WORD, 0, lat, q, mis);
        checkOutput("rvcLat", lat, 2);
        checkOutput("rvcMis", mis, 0);
        checkOutput("rvcQ", q, 32'h1234_5678);
        checkOutput("rvcBeats", beatAdr.size(), 1);
        if (beatAdr.size() == 1) begin
            checkOutput("rvcAdr", beatAdr[0], 32'h1000);
            checkOutput("rvcBe", beatBe[0], 4'b1111);
        end

        // crossing access with splitting disabled
        applyStimulus(1, 0, 0, 32'h1003, WORD, 0, lat, q, mis);
        checkOutput("noSplitLat", lat, 1);
        checkOutput("noSplitMis", mis, 1);
        checkOutput("noSplitNoReq", sawReq, 0);

        // address wrap on the second beat
        loData = 32'hA1B2_C3D4; hiAdr = 32'h0000_0000; hiData = 32'h0F0E_0D0C;
        applyStimulus(0, 0, 0, 32'hFFFF_FFFE, WORD, 0, lat, q, mis);
        checkOutput("wrapLat", lat, 3);
        checkOutput("wrapQ", q, 32'h0D0C_A1B2);
        checkOutput("wrapBeats", beatAdr.size(), 2);
        if (beatAdr.size() == 2) begin
            checkOutput("wrapAdr0", beatAdr[0], 32'hFFFF_FFFC);
            checkOutput("wrapBe0", beatBe[0], 4'b1100);
            checkOutput("wrapAdr1", beatAdr[1], 32'h0000_0000);
            checkOutput("wrapBe1", beatBe[1], 4'b0011);
        end

        // stalled second beat abandoned by reset
        loData = 32'h4433_2211; hiAdr = 32'h1004; hiData = 32'h8877_6655;
        @(negedge clk);
        selB = 1'b0;
        clearLog();
        instr = 1'b0; we = 1'b0; adr = 32'h1003; size = WORD; reqA = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reqA = 1'b0;
        @(negedge clk);
        holdAck = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("stallReq", memReqA, 1);
        checkOutput("stallAdr", memAdrA, 32'h1004);
        checkOutput("stallBe", memBeA, 4'b0111);
        rstN = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        holdAck = 1'b0;
        checkOutput("abortMemReq", memReqA, 0);
        checkOutput("abortReady", readyA, 1);
        checkOutput("abortAck", ackA, 0);
        checkOutput("abortNoAckSeen", ackSeen, 0);

        loData = 32'hCAFE_F00D; hiAdr = 32'hDEAD_0000;
        applyStimulus(0, 0, 0, 32'h1000, WORD, 0, lat, q, mis);
        checkOutput("postRstLat", lat, 2);
        checkOutput("postRstQ", q, 32'hCAFE_F00D);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
